// File: rtl/sme_param.sv
// String-match engine: buffers one string, then searches each loaded pattern (^ $ . and one *) against it.
// One char compare per cycle while busy; a load strobe during a search aborts it; inputs are never stalled.
module sme_param #(
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int IDX_W   = $clog2(MAX_STR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             busy,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index
);
  localparam int LW   = $clog2(MAX_STR + 1);
  localparam int PLW  = $clog2(MAX_PAT + 1);
  localparam int PI_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_S, LOAD_P, SEARCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    len_s_q, len_s_d;
  logic [PLW-1:0]   len_p_q, len_p_d;
  logic [7:0]       str_q [MAX_STR];
  logic [7:0]       pat_q [MAX_PAT];
  logic             str_we, pat_we;
  logic [IDX_W-1:0] str_wa;
  logic [PI_W-1:0]  pat_wa;
  logic             phase_q, phase_d;
  logic [LW-1:0]    pos_q, pos_d, pfx_q, pfx_d;
  logic [PLW-1:0]   off_q, off_d;
  logic             match_q, match_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Pattern body is [b0, b1); the first '*' inside it splits prefix and suffix.
  logic anc_s, anc_e, has_star;
  int   b0, b1, star_at, plen, slen;

  always_comb begin
    anc_s    = (len_p_q != '0) && (pat_q[0] == 8'h5E);
    b0       = anc_s ? 1 : 0;
    anc_e    = (int'(len_p_q) > b0) && (pat_q[PI_W'(len_p_q - 1'b1)] == 8'h24);
    b1       = int'(len_p_q) - (anc_e ? 1 : 0);
    has_star = 1'b0;
    star_at  = b1;
    for (int i = 0; i < MAX_PAT; i++) begin
      if (!has_star && i >= b0 && i < b1 && pat_q[i] == 8'h2A) begin
        has_star = 1'b1;
        star_at  = i;
      end
    end
    plen = star_at - b0;
    slen = has_star ? (b1 - star_at - 1) : 0;
  end

  // Phase 0 places the prefix (or whole body); phase 1 places the suffix after the prefix.
  int         need, base, seg_len, cpos, ppos, endp;
  logic [7:0] sc, pc;
  logic       eq, anchor_bad, end_chk, end_ok, seg_done;

  always_comb begin
    need       = phase_q ? slen : (plen + slen);
    base       = phase_q ? (star_at + 1) : b0;
    seg_len    = phase_q ? slen : plen;
    cpos       = int'(pos_q) + int'(off_q);
    ppos       = base + int'(off_q);
    sc         = str_q[IDX_W'(cpos)];
    pc         = pat_q[PI_W'(ppos)];
    eq         = (pc == 8'h2E) || (pc == sc);
    anchor_bad = !phase_q && anc_s && (off_q == '0) && (pos_q != '0) &&
                 (str_q[IDX_W'(int'(pos_q) - 1)] != 8'h20);
    end_chk    = anc_e && (phase_q == has_star);
    endp       = int'(pos_q) + seg_len;
    end_ok     = !end_chk || (endp == int'(len_s_q)) || (str_q[IDX_W'(endp)] == 8'h20);
    seg_done   = (int'(off_q) == seg_len - 1);
  end

  always_comb begin
    state_d = state_q;
    len_s_d = len_s_q;
    len_p_d = len_p_q;
    str_we  = 1'b0;
    pat_we  = 1'b0;
    str_wa  = '0;
    pat_wa  = '0;
    phase_d = phase_q;
    pos_d   = pos_q;
    off_d   = off_q;
    pfx_d   = pfx_q;
    match_d = match_q;
    idx_d   = idx_q;
    if (isstring) begin
      state_d = LOAD_S;
      if (state_q != LOAD_S) begin
        str_we  = 1'b1;
        len_s_d = LW'(1);
      end else if (int'(len_s_q) < MAX_STR) begin
        str_we  = 1'b1;
        str_wa  = IDX_W'(len_s_q);
        len_s_d = len_s_q + 1'b1;
      end
    end else if (ispattern) begin
      state_d = LOAD_P;
      if (state_q != LOAD_P) begin
        pat_we  = 1'b1;
        len_p_d = PLW'(1);
      end else if (int'(len_p_q) < MAX_PAT) begin
        pat_we  = 1'b1;
        pat_wa  = PI_W'(len_p_q);
        len_p_d = len_p_q + 1'b1;
      end
    end else begin
      case (state_q)
        LOAD_S: state_d = IDLE;
        LOAD_P: begin
          state_d = SEARCH;
          phase_d = (plen == 0);
          pos_d   = '0;
          off_d   = '0;
          pfx_d   = '0;
        end
        SEARCH: begin
          if (len_s_q == '0 || int'(pos_q) + need > int'(len_s_q)) begin
            state_d = DONE;
            match_d = 1'b0;
            idx_d   = '0;
          end else if (plen == 0 && slen == 0) begin
            state_d = DONE;
            match_d = 1'b1;
            idx_d   = '0;
          end else if (anchor_bad || !eq || (seg_done && !end_ok)) begin
            pos_d = pos_q + 1'b1;
            off_d = '0;
          end else if (!seg_done) begin
            off_d = off_q + 1'b1;
          end else if (!phase_q && has_star && slen != 0) begin
            // Later prefix starts only shrink the suffix window, so the leftmost prefix decides.
            phase_d = 1'b1;
            pfx_d   = pos_q;
            pos_d   = LW'(int'(pos_q) + plen);
            off_d   = '0;
          end else begin
            state_d = DONE;
            match_d = 1'b1;
            idx_d   = phase_q ? IDX_W'(pfx_q) : IDX_W'(pos_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (str_we) str_q[str_wa] <= chardata;
    if (pat_we) pat_q[pat_wa] <= chardata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_s_q <= '0;
      len_p_q <= '0;
      phase_q <= 1'b0;
      pos_q   <= '0;
      off_q   <= '0;
      pfx_q   <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_s_q <= len_s_d;
      len_p_q <= len_p_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      off_q   <= off_d;
      pfx_q   <= pfx_d;
      match_q <= match_d;
      idx_q   <= idx_d;
    end
  end

  assign busy        = (state_q == SEARCH);
  assign valid       = (state_q == DONE);
  assign match       = valid & match_q;
  assign match_index = valid ? idx_q : '0;

endmodule
